clkmgr_root_ctrl_multi: RTL



---
 rtl/clkmgr_root_ctrl_pkg.sv | 30 +++
 rtl/clkmgr_root_ctrl_multi_if.sv | 34 +++
 rtl/clkmgr_root_chan.sv | 114 +++++++++++
 rtl/prim_clock_gating.sv | 17 +
 rtl/clkmgr_root_ctrl_multi.sv | 61 ++++++
 5 files changed

// File: rtl/clkmgr_root_ctrl_pkg.sv
// Shared types for the multi-channel root clock controller: multi-bit scan encoding,
// per-channel FSM state encoding and counter sizing.
package clkmgr_root_ctrl_pkg;

  typedef logic [3:0] mubi4_t;

  localparam mubi4_t MuBi4True  = 4'hA;
  localparam mubi4_t MuBi4False = 4'h5;

  localparam int GateCntW = 16;

  // Every state pair differs in at least two bits, so one upset cannot yield another legal state
  typedef enum logic [3:0] {
    RootOff      = 4'b1001,
    RootArm      = 4'b1110,
    RootOn       = 4'b0111,
    RootIdleWait = 4'b0000
  } root_chan_state_e;

  function automatic logic mubi4_test_true_strict(mubi4_t val);
    return val == MuBi4True;
  endfunction

  function automatic int cnt_width(int on_cycles, int idle_cycles);
    int max_cycles;
    max_cycles = (on_cycles > idle_cycles) ? on_cycles : idle_cycles;
    return $clog2(max_cycles + 1);
  endfunction

endpackage

// File: rtl/clkmgr_root_ctrl_multi_if.sv
// Request/status bundle between clkmgr and the root controller.
// Carries gate_cnt_o only when CLKMGR_ROOT_GATE_CNT_EN is defined.
interface clkmgr_root_ctrl_multi_if #(
  parameter int NumChans = 4
);
  import clkmgr_root_ctrl_pkg::*;

  mubi4_t              scanmode_i;
  logic [NumChans-1:0] en_req_i;
  logic [NumChans-1:0] idle_i;
  logic [NumChans-1:0] en_o;
  logic [NumChans-1:0] clk_o;
  logic                busy_o;
`ifdef CLKMGR_ROOT_GATE_CNT_EN
  logic [NumChans-1:0][GateCntW-1:0] gate_cnt_o;
`endif

  modport master (
    output scanmode_i, en_req_i, idle_i,
`ifdef CLKMGR_ROOT_GATE_CNT_EN
    input  gate_cnt_o,
`endif
    input  en_o, clk_o, busy_o
  );

  modport slave (
    input  scanmode_i, en_req_i, idle_i,
`ifdef CLKMGR_ROOT_GATE_CNT_EN
    output gate_cnt_o,
`endif
    output en_o, clk_o, busy_o
  );

endinterface

// File: rtl/clkmgr_root_chan.sv
// One root clock channel: request synchroniser, on-delay / idle hysteresis FSM and gate.
// Optional Off->Arm transition counter under CLKMGR_ROOT_GATE_CNT_EN.
module clkmgr_root_chan
  import clkmgr_root_ctrl_pkg::*;
#(
  parameter int SyncStages = 2,
  parameter int OnCycles   = 2,
  parameter int IdleCycles = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic scan_on,
  input  logic en_req,
  input  logic idle,
  output logic en,
  output logic active,
  output logic clk_gated
`ifdef CLKMGR_ROOT_GATE_CNT_EN
  ,
  output logic [GateCntW-1:0] gate_cnt
`endif
);

  localparam int CntW = cnt_width(OnCycles, IdleCycles);
  localparam logic [CntW-1:0] OnLast   = CntW'(OnCycles - 1);
  localparam logic [CntW-1:0] IdleLast = CntW'(IdleCycles - 1);

  logic [SyncStages-1:0] sync_q;
  logic                  req_s;
  root_chan_state_e      state;
  logic [CntW-1:0]       cnt;
  logic                  gate_en;

  always_ff @(posedge clk) begin
    if (rst) sync_q <= '0;
    else     sync_q <= {sync_q[SyncStages-2:0], en_req};
  end

  assign req_s = sync_q[SyncStages-1];

  // The counter is zeroed on every transition so each state starts counting from scratch
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RootOff;
      cnt   <= '0;
      en    <= 1'b0;
    end else begin
      en <= (state == RootOn) || (state == RootIdleWait);
      case (state)
        RootOff: begin
          if (req_s) begin
            state <= RootArm;
            cnt   <= '0;
          end
        end
        RootArm: begin
          if (!req_s) begin
            state <= RootIdleWait;
            cnt   <= '0;
          end else if (cnt == OnLast) begin
            state <= RootOn;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RootOn: begin
          if (!req_s) begin
            state <= RootIdleWait;
            cnt   <= '0;
          end
        end
        RootIdleWait: begin
          if (req_s) begin
            state <= RootOn;
            cnt   <= '0;
          end else if (!idle) begin
            cnt <= '0;
          end else if (cnt == IdleLast) begin
            state <= RootOff;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= RootOff;
          cnt   <= '0;
        end
      endcase
    end
  end

  assign active  = (state == RootArm) || (state == RootIdleWait);
  assign gate_en = (state != RootOff) || scan_on;

  prim_clock_gating u_gate (
    .clk_i     (clk),
    .en_i      (gate_en),
    .test_en_i (scan_on),
    .clk_o     (clk_gated)
  );

`ifdef CLKMGR_ROOT_GATE_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      gate_cnt <= '0;
    end else if ((state == RootOff) && req_s && (gate_cnt != '1)) begin
      gate_cnt <= gate_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: rtl/prim_clock_gating.sv
// Glitch-free latch-based clock gate; enable is captured while the clock is low.
module prim_clock_gating (
  input  logic clk_i,
  input  logic en_i,
  input  logic test_en_i,
  output logic clk_o
);

  logic en_latch;

  always_latch begin
    if (!clk_i) en_latch = en_i | test_en_i;
  end

  assign clk_o = clk_i & en_latch;

endmodule

// File: rtl/clkmgr_root_ctrl_multi.sv
// Multi-channel root clock controller: NumChans gated roots from one source clock.
// Define CLKMGR_ROOT_GATE_CNT_EN to expose per-channel gate-on event counters.
module clkmgr_root_ctrl_multi
  import clkmgr_root_ctrl_pkg::*;
#(
  parameter int NumChans   = 4,
  parameter int SyncStages = 2,
  parameter int OnCycles   = 2,
  parameter int IdleCycles = 8
) (
  input  logic clk_i,
  input  logic rst_i,
  clkmgr_root_ctrl_multi_if.slave bus
);

  mubi4_t              scan_q;
  logic                scan_on;
  logic [NumChans-1:0] en_vec;
  logic [NumChans-1:0] active_vec;
  logic [NumChans-1:0] clk_vec;
  logic                busy_q;

  // Only the strict true pattern opens the gates; corrupted encodings read as functional mode
  always_ff @(posedge clk_i) begin
    if (rst_i) scan_q <= MuBi4False;
    else       scan_q <= bus.scanmode_i;
  end

  assign scan_on = mubi4_test_true_strict(scan_q);

  for (genvar k = 0; k < NumChans; k++) begin : g_chan
    clkmgr_root_chan #(
      .SyncStages (SyncStages),
      .OnCycles   (OnCycles),
      .IdleCycles (IdleCycles)
    ) u_chan (
      .clk       (clk_i),
      .rst       (rst_i),
      .scan_on   (scan_on),
      .en_req    (bus.en_req_i[k]),
      .idle      (bus.idle_i[k]),
      .en        (en_vec[k]),
      .active    (active_vec[k]),
      .clk_gated (clk_vec[k])
`ifdef CLKMGR_ROOT_GATE_CNT_EN
      ,
      .gate_cnt  (bus.gate_cnt_o[k])
`endif
    );
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) busy_q <= 1'b0;
    else       busy_q <= |active_vec;
  end

  assign bus.en_o   = en_vec;
  assign bus.clk_o  = clk_vec;
  assign bus.busy_o = busy_q;

endmodule
